// File: rtl/cpu_mem_port.sv
// Memory-side port for the LC-3b multicycle CPU: registers each MAR/MDR request,
// runs it over a req/ack physical bus with timeout abort, and returns a one-cycle mem_resp.
module cpu_mem_port #(
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CNTW      = 16,
  parameter logic [15:0] ERR_RDATA = 16'hDEAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        pmem_req,
  output logic        pmem_we,
  output logic [15:0] pmem_addr,
  output logic [1:0]  pmem_wmask,
  output logic [15:0] pmem_wdata,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_ack,
  input  logic        err_clr,
  output logic [1:0]  err_flags
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

  logic [1:0]      state_q, state_d;
  logic [15:0]     addr_q, addr_d;
  logic            we_q, we_d;
  logic [1:0]      wmask_q, wmask_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [15:0]     rdata_q, rdata_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [1:0]      err_q, err_d;
  logic            set_timeout, set_conflict;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wmask_d      = wmask_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    set_timeout  = 1'b0;
    set_conflict = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          state_d      = REQ;
          addr_d       = {mem_address[15:1], 1'b0};
          // A read+write conflict is resolved as a write and flagged.
          we_d         = mem_write;
          wmask_d      = mem_write ? mem_byte_enable : 2'b00;
          wdata_d      = mem_wdata;
          cnt_d        = '0;
          set_conflict = mem_read && mem_write;
        end
      end
      REQ: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNTW'(1);
        end
        // Ack on the expiry cycle takes priority over the timeout.
        if (pmem_ack) begin
          state_d = RESP;
          if (!we_q) begin
            rdata_d = pmem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          rdata_d     = ERR_RDATA;
          set_timeout = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Clear first so a same-cycle set survives.
  always_comb begin
    err_d = err_clr ? 2'b00 : err_q;
    if (set_timeout) begin
      err_d[0] = 1'b1;
    end
    if (set_conflict) begin
      err_d[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wmask_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign pmem_req   = (state_q == REQ) && !rst;
  assign pmem_we    = we_q;
  assign pmem_addr  = addr_q;
  assign pmem_wmask = wmask_q;
  assign pmem_wdata = wdata_q;
  assign mem_resp   = (state_q == RESP);
  assign mem_rdata  = rdata_q;
  assign err_flags  = err_q;

endmodule

// File: tb/tb_cpu_mem_port.sv
// Directed bench for cpu_mem_port: scoreboard of expected responses popped on mem_resp.
module tb_cpu_mem_port;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_resp;
  logic        pmem_req, pmem_we;
  logic [15:0] pmem_addr, pmem_wdata, pmem_rdata;
  logic [1:0]  pmem_wmask;
  logic        pmem_ack;
  logic        err_clr;
  logic [1:0]  err_flags;

  typedef struct packed {
    logic [15:0] rdata;
    logic [1:0]  flags;
  } resp_t;

  resp_t       sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rises = 0;
  logic        req_prev = 1'b0;
  logic [15:0] model_rdata = 16'h0000;
  logic [1:0]  model_flags = 2'b00;

  cpu_mem_port #(
    .TIMEOUT  (TO),
    .CNTW     (4),
    .ERR_RDATA(16'hDEAD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_byte_enable(mem_byte_enable),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp),
    .pmem_req       (pmem_req),
    .pmem_we        (pmem_we),
    .pmem_addr      (pmem_addr),
    .pmem_wmask     (pmem_wmask),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_ack       (pmem_ack),
    .err_clr        (err_clr),
    .err_flags      (err_flags)
  );

  always #5 clk = ~clk;

  // Count physical requests issued (rising edges of pmem_req).
  always @(negedge clk) begin
    if (pmem_req && !req_prev) rises++;
    req_prev = pmem_req;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete CPU access; ack_dly = REQ-cycle edges before ack (>= TO means never ack).
  task automatic access(input logic rd, input logic wr, input logic [1:0] be,
                        input logic [15:0] addr, input logic [15:0] wd,
                        input int ack_dly, input logic [15:0] ack_data);
    resp_t exp;
    resp_t got;
    int    hi;
    int    k;
    int    exp_hi;
    logic  timed_out;
    timed_out = (ack_dly >= int'(TO));
    if (wr && rd) model_flags[1] = 1'b1;
    if (timed_out) begin
      model_flags[0] = 1'b1;
      model_rdata    = 16'hDEAD;
    end else if (!wr) begin
      model_rdata = ack_data;
    end
    exp.rdata = model_rdata;
    exp.flags = model_flags;
    sb_q.push_back(exp);
    exp_hi = timed_out ? int'(TO) : ack_dly + 1;

    mem_read        = rd;
    mem_write       = wr;
    mem_byte_enable = be;
    mem_address     = addr;
    mem_wdata       = wd;
    step();
    check("req_rise", {31'd0, pmem_req}, 32'd1);
    check("pmem_addr", {16'd0, pmem_addr}, {16'd0, addr[15:1], 1'b0});
    check("pmem_we", {31'd0, pmem_we}, {31'd0, wr});
    check("pmem_wmask", {30'd0, pmem_wmask}, {30'd0, (wr ? be : 2'b00)});
    check("pmem_wdata", {16'd0, pmem_wdata}, {16'd0, wd});

    hi = 1;
    k  = 0;
    while (k < ack_dly && pmem_req) begin
      step();
      k++;
      if (pmem_req) hi++;
    end
    if (pmem_req) begin
      pmem_ack   = 1'b1;
      pmem_rdata = ack_data;
      step();
      pmem_ack   = 1'b0;
      pmem_rdata = 16'h0000;
    end
    check("req_cycles", hi, exp_hi);
    check("resp", {31'd0, mem_resp}, 32'd1);
    check("req_low_resp", {31'd0, pmem_req}, 32'd0);
    if (mem_resp && sb_q.size() > 0) begin
      got = sb_q.pop_front();
      check("mem_rdata", {16'd0, mem_rdata}, {16'd0, got.rdata});
      check("err_flags", {30'd0, err_flags}, {30'd0, got.flags});
    end else begin
      check("resp_seen", 32'd0, 32'd1);
    end

    // Request still held through RESP must not be re-issued.
    step();
    check("resp_one_cycle", {31'd0, mem_resp}, 32'd0);
    check("no_reissue", {31'd0, pmem_req}, 32'd0);
    check("rdata_hold", {16'd0, mem_rdata}, {16'd0, model_rdata});
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00;
    mem_address = 16'h0000; mem_wdata = 16'h0000;
    pmem_rdata = 16'h0000; pmem_ack = 1'b0; err_clr = 1'b0;
    step();
    step();
    check("rst_req", {31'd0, pmem_req}, 32'd0);
    check("rst_resp", {31'd0, mem_resp}, 32'd0);
    check("rst_rdata", {16'd0, mem_rdata}, 32'd0);
    check("rst_flags", {30'd0, err_flags}, 32'd0);
    rst = 1'b0;
    step();

    // Read with 3-cycle ack delay.
    access(1'b1, 1'b0, 2'b00, 16'h1235, 16'h0000, 3, 16'hBEEF);
    // Byte store, immediate ack.
    access(1'b0, 1'b1, 2'b10, 16'h0041, 16'hAB00, 0, 16'h0000);
    // Timeout on a never-acked read, then clear.
    access(1'b1, 1'b0, 2'b00, 16'h0100, 16'h0000, 100, 16'h0000);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    model_flags = 2'b00;
    check("err_clr", {30'd0, err_flags}, 32'd0);
    // Ack on the expiry cycle wins.
    access(1'b1, 1'b0, 2'b00, 16'h0200, 16'h0000, TO - 1, 16'h5555);
    // Read/write conflict, then back-to-back read in the following IDLE cycle.
    access(1'b1, 1'b1, 2'b11, 16'h2003, 16'h1234, 1, 16'h0000);
    access(1'b1, 1'b0, 2'b00, 16'h3000, 16'h0000, 0, 16'h0F0F);
    step();
    check("req_count", rises, 6);
    check("sb_empty", sb_q.size(), 0);

    // Asynchronous reset mid-REQ.
    mem_read    = 1'b1;
    mem_address = 16'h4444;
    step();
    check("pre_rst_req", {31'd0, pmem_req}, 32'd1);
    #3 rst = 1'b1;
    #1;
    check("async_req", {31'd0, pmem_req}, 32'd0);
    check("async_addr", {16'd0, pmem_addr}, 32'd0);
    check("async_we", {31'd0, pmem_we}, 32'd0);
    check("async_wmask", {30'd0, pmem_wmask}, 32'd0);
    check("async_wdata", {16'd0, pmem_wdata}, 32'd0);
    check("async_rdata", {16'd0, mem_rdata}, 32'd0);
    check("async_flags", {30'd0, err_flags}, 32'd0);
    mem_read = 1'b0;
    step();
    rst = 1'b0;
    pmem_ack = 1'b1;
    pmem_rdata = 16'h7777;
    step();
    check("late_ack_resp", {31'd0, mem_resp}, 32'd0);
    check("late_ack_req", {31'd0, pmem_req}, 32'd0);
    pmem_ack = 1'b0;
    step();
    check("late_ack_resp2", {31'd0, mem_resp}, 32'd0);
    check("late_ack_rdata", {16'd0, mem_rdata}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
